// File: rtl/conv_pkg.sv
// Shared conv datapath widths: used by the delay stage, the weight fetch and the MAC accumulator.
package conv_pkg;

    localparam int DATA_BW_DEF    = 8;
    localparam int WEIGHT_BW_DEF  = 8;
    localparam int KERNEL_LEN_DEF = 9;
    localparam int PROD_BW_DEF    = DATA_BW_DEF + WEIGHT_BW_DEF;

    // Widest full-precision dot product: product width plus one bit per doubling of taps.
    function automatic int conv_acc_bw(input int prod_bw, input int kernel_len);
        return prod_bw + $clog2(kernel_len);
    endfunction

    localparam int ACC_BW_DEF = conv_acc_bw(PROD_BW_DEF, KERNEL_LEN_DEF);

endpackage

// File: rtl/conv_result_slot.sv
// One-entry valid/ready output register for the MAC result; applies the optional ReLU clamp on load.
// Build option: define CONV_MAC_RELU_EN to clamp negative results to zero.
module conv_result_slot #(
    parameter int ACC_BW = conv_pkg::ACC_BW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic signed [ACC_BW-1:0] load_acc,
    input  logic                     drain,
    output logic                     o_valid,
    output logic signed [ACC_BW-1:0] o_acc
);

    logic signed [ACC_BW-1:0] load_val;

`ifdef CONV_MAC_RELU_EN
    assign load_val = load_acc[ACC_BW-1] ? '0 : load_acc;
`else
    assign load_val = load_acc;
`endif

    // A load wins over a drain so back-to-back results pass without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_acc   <= '0;
        end else if (load) begin
            o_valid <= 1'b1;
            o_acc   <= load_val;
        end else if (drain) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_mac_accum.sv
// Multiply-accumulate of KERNEL_LEN delayed samples by kernel weights into one signed result slot.
// Build option: CONV_MAC_RELU_EN enables a ReLU clamp on the value presented at o_acc.
module conv_mac_accum
    import conv_pkg::*;
#(
    parameter int DATA_BW    = DATA_BW_DEF,
    parameter int WEIGHT_BW  = WEIGHT_BW_DEF,
    parameter int KERNEL_LEN = KERNEL_LEN_DEF,
    parameter int ACC_BW     = conv_acc_bw(DATA_BW + WEIGHT_BW, KERNEL_LEN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    input  logic signed [DATA_BW-1:0]   i_x,
    input  logic signed [WEIGHT_BW-1:0] i_w,
    output logic                        o_ready,
    input  logic                        i_clear,
    output logic                        o_valid,
    output logic signed [ACC_BW-1:0]    o_acc,
    input  logic                        i_ready
);

    localparam int PROD_BW = DATA_BW + WEIGHT_BW;
    localparam int CNT_BW  = $clog2(KERNEL_LEN);
    localparam logic [CNT_BW-1:0] LAST_TAP = CNT_BW'(KERNEL_LEN - 1);

    logic [CNT_BW-1:0]        tap_cnt;
    logic signed [ACC_BW-1:0] acc;
    logic signed [PROD_BW-1:0] prod;
    logic signed [ACC_BW-1:0] prod_ext;
    logic signed [ACC_BW-1:0] sum;
    logic                     is_last;
    logic                     accept;
    logic                     load;

    assign prod     = PROD_BW'(i_x) * PROD_BW'(i_w);
    assign prod_ext = ACC_BW'(prod);
    assign sum      = acc + prod_ext;

    // Only the closing tap can be held back, and only while the slot is full and not draining.
    assign is_last = (tap_cnt == LAST_TAP);
    assign o_ready = !is_last || !o_valid || i_ready;
    assign accept  = i_valid && o_ready && !i_clear;
    assign load    = accept && is_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt <= '0;
            acc     <= '0;
        end else if (i_clear) begin
            tap_cnt <= '0;
            acc     <= '0;
        end else if (accept) begin
            if (is_last) begin
                tap_cnt <= '0;
                acc     <= '0;
            end else begin
                tap_cnt <= tap_cnt + 1'b1;
                acc     <= sum;
            end
        end
    end

    conv_result_slot #(
        .ACC_BW (ACC_BW)
    ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_acc (sum),
        .drain    (i_ready),
        .o_valid  (o_valid),
        .o_acc    (o_acc)
    );

endmodule

// File: tb/tb_conv_mac_accum.sv
// Directed and randomized-handshake checks of conv_mac_accum against hand-computed dot products.
module tb_conv_mac_accum;

    logic              clk;
    logic              rst;
    logic              i_valid;
    logic signed [7:0] i_x;
    logic signed [7:0] i_w;
    logic              o_ready;
    logic              i_clear;
    logic              o_valid;
    logic signed [19:0] o_acc;
    logic              i_ready;

    int compared   = 0;
    int mismatched = 0;

    conv_mac_accum #(
        .DATA_BW    (8),
        .WEIGHT_BW  (8),
        .KERNEL_LEN (9),
        .ACC_BW     (20)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_x     (i_x),
        .i_w     (i_w),
        .o_ready (o_ready),
        .i_clear (i_clear),
        .o_valid (o_valid),
        .o_acc   (o_acc),
        .i_ready (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit valid, input int x, input int w, input bit rdy, input bit clr);
        i_valid = valid;
        i_x     = 8'(x);
        i_w     = 8'(w);
        i_ready = rdy;
        i_clear = clr;
    endtask

    // Advance one full clock: inputs are driven and outputs read at the falling edge.
    task automatic waitCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one pair until it is accepted, then withdraw it.
    task automatic pushTap(input int x, input int w);
        bit done;
        done = 1'b0;
        applyStimulus(1'b1, x, w, i_ready, 1'b0);
        for (int n = 0; n < 50 && !done; n++) begin
            #1;
            done = o_ready;
            waitCycle();
        end
        i_valid = 1'b0;
        checkOutput("tap_accept", int'(done), 1);
    endtask

    function automatic int expResult(input int s);
`ifdef CONV_MAC_RELU_EN
        return (s < 0) ? 0 : s;
`else
        return s;
`endif
    endfunction

    initial begin
        int exp_q[$];
        int dot, taps, windows_sent, drained, cyc, xi, wi, obs;
        bit do_valid, acc_now, drain_now;

        rst = 1'b1;
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        #1;
        checkOutput("rst_valid", int'(o_valid), 0);
        checkOutput("rst_acc", int'(o_acc), 0);
        checkOutput("rst_ready", int'(o_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        waitCycle();

        // Ramp window: 1+2+...+9
        i_ready = 1'b1;
        for (int k = 1; k <= 9; k++) pushTap(k, 1);
        checkOutput("ramp_valid", int'(o_valid), 1);
        checkOutput("ramp_acc", int'(o_acc), 45);
        waitCycle();
        checkOutput("ramp_drained", int'(o_valid), 0);

        // Largest positive product in every tap
        for (int k = 0; k < 9; k++) pushTap(-128, -128);
        checkOutput("maxpos_acc", int'(o_acc), 147456);
        waitCycle();

        // Largest negative product in every tap
        for (int k = 0; k < 9; k++) pushTap(-128, 127);
`ifdef CONV_MAC_RELU_EN
        checkOutput("maxneg_acc", int'(o_acc), 0);
`else
        checkOutput("maxneg_acc", int'(o_acc), -146304);
`endif
        waitCycle();

        // Held result with a second window streaming behind it
        i_ready = 1'b0;
        for (int k = 1; k <= 9; k++) pushTap(k, 1);
        checkOutput("hold_first", int'(o_acc), 45);
        for (int k = 0; k < 8; k++) pushTap(2, 1);
        checkOutput("hold_stable", int'(o_acc), 45);
        checkOutput("hold_valid", int'(o_valid), 1);
        applyStimulus(1'b1, 2, 1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("stall_ready", int'(o_ready), 0);
            waitCycle();
            checkOutput("stall_acc", int'(o_acc), 45);
        end
        i_ready = 1'b1;
        #1;
        checkOutput("release_ready", int'(o_ready), 1);
        waitCycle();
        checkOutput("swap_valid", int'(o_valid), 1);
        checkOutput("swap_acc", int'(o_acc), 18);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        waitCycle();
        checkOutput("swap_drained", int'(o_valid), 0);

        // Abort after four taps; the pair presented with the clear is dropped
        for (int k = 1; k <= 4; k++) pushTap(k, 1);
        applyStimulus(1'b1, 100, 1, 1'b1, 1'b1);
        waitCycle();
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        checkOutput("clear_novalid", int'(o_valid), 0);
        for (int k = 0; k < 9; k++) pushTap(2, 3);
        checkOutput("clear_acc", int'(o_acc), 54);
        waitCycle();

        // Reset with a held result and five taps in flight
        i_ready = 1'b0;
        for (int k = 0; k < 9; k++) pushTap(1, 1);
        checkOutput("prerst_acc", int'(o_acc), 9);
        for (int k = 0; k < 5; k++) pushTap(3, 3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", int'(o_valid), 0);
        checkOutput("async_rst_acc", int'(o_acc), 0);
        @(negedge clk);
        rst = 1'b0;
        i_ready = 1'b1;
        for (int k = 1; k <= 9; k++) pushTap(k, 2);
        checkOutput("postrst_acc", int'(o_acc), 90);
        waitCycle();

        // Random valid/ready gaps, scoreboarded against reference dot products
        dot = 0; taps = 0; windows_sent = 0; drained = 0; cyc = 0;
        while ((windows_sent < 1000 || exp_q.size() != 0) && cyc < 60000) begin
            do_valid = (windows_sent < 1000) && ($urandom_range(3) != 0);
            xi = int'($urandom_range(255)) - 128;
            wi = int'($urandom_range(255)) - 128;
            applyStimulus(do_valid, xi, wi, ($urandom_range(1) == 1), 1'b0);
            #1;
            acc_now   = do_valid && o_ready;
            drain_now = o_valid && i_ready;
            obs       = int'(o_acc);
            waitCycle();
            cyc++;
            if (drain_now) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rnd_spurious", exp_q.size(), 1);
                end else begin
                    checkOutput("rnd_acc", obs, exp_q.pop_front());
                    drained++;
                end
            end
            if (acc_now) begin
                dot += xi * wi;
                taps++;
                if (taps == 9) begin
                    exp_q.push_back(expResult(dot));
                    dot = 0;
                    taps = 0;
                    windows_sent++;
                end
            end
        end
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
        waitCycle();
        checkOutput("rnd_drained", drained, 1000);
        checkOutput("rnd_empty", int'(o_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
